tpu_result_reader: RTL and testbench

- Read-back engine for the per-batch output SRAMs that tpu_top fills through its write ports (wsb/waddr/wdata).
- After the TPU finishes, it reads every output row of every batch and serializes each row into OUT_DATA_WIDTH words.
- Words leave on a valid/ready stream toward the host/DMA side.
- It is the reader at the far end of the output-SRAM write interface.

---
 rtl/tpu_result_reader.sv | 167 ++++++++++++++++
 tb/tb_tpu_result_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_reader.sv
// Read-back engine for the per-batch output SRAMs: walks every row of every batch,
// fetches it with a one-cycle read and streams it out one column word at a time.
module tpu_result_reader #(
    parameter int ARRAY_SIZE     = 8,
    parameter int BATCH_SIZE     = 3,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int NUM_ROWS       = 2*ARRAY_SIZE-1,
    parameter int MATRIX_BITS    = $clog2(2*ARRAY_SIZE-1),
    parameter int BATCH_BITS     = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
    parameter int COL_BITS       = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                           clk,
    input  logic                                           srstn,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    output logic [MATRIX_BITS-1:0]                         sram_raddr,
    output logic [BATCH_SIZE-1:0]                          sram_csb_n,
    input  logic [BATCH_SIZE*ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_packed,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [OUT_DATA_WIDTH-1:0]                      out_data,
    output logic [BATCH_BITS-1:0]                          out_batch,
    output logic [MATRIX_BITS-1:0]                         out_row,
    output logic [COL_BITS-1:0]                            out_col,
    output logic                                           out_last
);

    localparam int ROW_W = ARRAY_SIZE*OUT_DATA_WIDTH;
    localparam logic [BATCH_BITS-1:0]  BATCH_MAX = BATCH_BITS'(BATCH_SIZE-1);
    localparam logic [MATRIX_BITS-1:0] ROW_MAX   = MATRIX_BITS'(NUM_ROWS-1);
    localparam logic [COL_BITS-1:0]    COL_MAX   = COL_BITS'(ARRAY_SIZE-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [BATCH_BITS-1:0]     batch_r, batch_s;
    logic [MATRIX_BITS-1:0]    row_r, row_s;
    logic [COL_BITS-1:0]       col_r, col_s;
    logic [ROW_W-1:0]          row_buf_r, buf_s;
    logic [OUT_DATA_WIDTH-1:0] out_data_r, out_data_s;
    logic [BATCH_SIZE-1:0]     csb_r, csb_s;
    logic                      busy_r, done_r, valid_r, last_r, hs_s;

    function automatic logic is_last(input logic [BATCH_BITS-1:0] b,
                                     input logic [MATRIX_BITS-1:0] r,
                                     input logic [COL_BITS-1:0] c);
        return (b == BATCH_MAX) && (r == ROW_MAX) && (c == COL_MAX);
    endfunction

    // Next state, next counters and row-buffer capture.
    always_comb begin
        state_s = state_r;
        batch_s = batch_r;
        row_s   = row_r;
        col_s   = col_r;
        buf_s   = row_buf_r;
        hs_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // The done cycle still belongs to the finished transfer, so start waits one more cycle.
                if (start && !done_r) begin
                    state_s = RD;
                    batch_s = BATCH_BITS'(0);
                    row_s   = MATRIX_BITS'(0);
                    col_s   = COL_BITS'(0);
                end else begin
                    state_s = IDLE;
                end
            end
            RD: state_s = WAIT;
            WAIT: begin
                buf_s   = sram_rdata_packed[batch_r*ROW_W +: ROW_W];
                state_s = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    hs_s = 1'b1;
                    if (col_r != COL_MAX) begin
                        col_s = col_r + COL_BITS'(1);
                    end else begin
                        col_s = COL_BITS'(0);
                        if (row_r != ROW_MAX) begin
                            row_s = row_r + MATRIX_BITS'(1);
                        end else begin
                            row_s   = MATRIX_BITS'(0);
                            batch_s = (batch_r == BATCH_MAX) ? BATCH_BITS'(0) : batch_r + BATCH_BITS'(1);
                        end
                    end
                    if (is_last(batch_r, row_r, col_r)) begin
                        state_s = IDLE;
                    end else if (col_r == COL_MAX) begin
                        state_s = RD;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        csb_s      = {BATCH_SIZE{1'b1}};
        out_data_s = buf_s[col_s*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
        for (int b = 0; b < BATCH_SIZE; b++) begin
            if ((state_s == RD) && (batch_s == BATCH_BITS'(b))) begin
                csb_s[b] = 1'b0;
            end else begin
                csb_s[b] = 1'b1;
            end
        end
    end

    // State, counters, row buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_r    <= IDLE;
            batch_r    <= BATCH_BITS'(0);
            row_r      <= MATRIX_BITS'(0);
            col_r      <= COL_BITS'(0);
            row_buf_r  <= {ROW_W{1'b0}};
            out_data_r <= {OUT_DATA_WIDTH{1'b0}};
            csb_r      <= {BATCH_SIZE{1'b1}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            batch_r   <= batch_s;
            row_r     <= row_s;
            col_r     <= col_s;
            row_buf_r <= buf_s;
            csb_r     <= csb_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= hs_s && is_last(batch_r, row_r, col_r);
            valid_r   <= (state_s == SEND);
            last_r    <= (state_s == SEND) && is_last(batch_s, row_s, col_s);
            if (state_s == SEND) begin
                out_data_r <= out_data_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign sram_raddr = row_r;
    assign sram_csb_n = csb_r;
    assign out_valid  = valid_r;
    assign out_data   = out_data_r;
    assign out_batch  = batch_r;
    assign out_row    = row_r;
    assign out_col    = col_r;
    assign out_last   = last_r;

endmodule

// File: tb/tb_tpu_result_reader.sv
// Randomized bench for tpu_result_reader: SRAM model plus expected word order from batch/row/col arithmetic.
module tb_tpu_result_reader;

    localparam int A  = 8;
    localparam int B  = 3;
    localparam int W  = 16;
    localparam int NR = 2*A-1;
    localparam int MB = 4;
    localparam int BW = 2;
    localparam int CW = 3;
    localparam int TOTAL = B*NR*A;

    logic            clk = 1'b0;
    logic            srstn, start, out_ready;
    logic            busy, done, out_valid, out_last;
    logic [MB-1:0]   sram_raddr, out_row;
    logic [B-1:0]    sram_csb_n;
    logic [B*A*W-1:0] rdata;
    logic [W-1:0]    out_data;
    logic [BW-1:0]   out_batch;
    logic [CW-1:0]   out_col;

    logic [W-1:0] mem [B][NR][A];

    int vectors = 0, miscompares = 0;
    int mon_idx = 0, mon_err = 0, mon_base = 0;
    int mon_rel, mon_eb, mon_ea;
    logic [B-1:0] mon_ecsb;

    tpu_result_reader dut (
        .clk(clk), .srstn(srstn), .start(start), .busy(busy), .done(done),
        .sram_raddr(sram_raddr), .sram_csb_n(sram_csb_n), .sram_rdata_packed(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_batch(out_batch), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAMs; unselected outputs carry junk so a wrong slice shows up.
    always @(posedge clk) begin
        for (int b = 0; b < B; b++) begin
            for (int k = 0; k < A; k++) begin
                if (!sram_csb_n[b] && sram_raddr < MB'(NR)) rdata[(b*A+k)*W +: W] <= mem[b][sram_raddr][k];
                else rdata[(b*A+k)*W +: W] <= W'($urandom);
            end
        end
    end

    // Read-port monitor: reads must walk batch-major, row 0..NR-1, one-hot select, never while streaming.
    always @(negedge clk) begin
        if (srstn === 1'b1 && sram_csb_n !== {B{1'b1}}) begin
            mon_rel  = mon_idx - mon_base;
            mon_eb   = mon_rel / NR;
            mon_ea   = mon_rel % NR;
            mon_ecsb = {B{1'b1}};
            if (mon_eb < B) mon_ecsb[mon_eb] = 1'b0;
            if (sram_csb_n !== mon_ecsb || sram_raddr !== MB'(mon_ea) ||
                out_batch !== BW'(mon_eb) || out_valid !== 1'b0) begin
                $display("FAIL sram_read #%0d: csb_n=%b raddr=%0d out_batch=%0d valid=%b, required csb_n=%b raddr=%0d batch=%0d valid=0",
                         mon_rel, sram_csb_n, sram_raddr, out_batch, out_valid, mon_ecsb, mon_ea, mon_eb);
                mon_err++;
            end
            mon_idx++;
        end
    end

    task automatic fill_pattern();
        for (int b = 0; b < B; b++)
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < A; k++)
                    mem[b][r][k] = W'((b << 12) | (r << 4) | k);
    endtask

    task automatic fill_random();
        for (int b = 0; b < B; b++)
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < A; k++)
                    mem[b][r][k] = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
            out_batch !== 2'd0 || out_row !== 4'd0 || out_col !== 3'd0 || out_last !== 1'b0 ||
            sram_raddr !== 4'd0 || sram_csb_n !== 3'b111) begin
            $display("FAIL %s: busy=%b done=%b valid=%b data=%h b/r/c=%0d/%0d/%0d last=%b raddr=%0d csb_n=%b, required all zero and csb_n=111",
                     name, busy, done, out_valid, out_data, out_batch, out_row, out_col, out_last, sram_raddr, sram_csb_n);
            miscompares++;
        end
    endtask

    // Runs one transfer from start; optionally pokes start mid-stream or resets at a given word.
    task automatic run_transfer(input string name, input int ready_pct, input int restart_word,
                                input int reset_word, input bit check_latency);
        int word, cyc, eb, er, ek, err0;
        mon_base = mon_idx;
        err0 = mon_err;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc  = 1;
        word = 0;
        while (word < TOTAL && cyc < 5000) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL %s busy_done cyc %0d: busy=%b done=%b, required busy=1 done=0", name, cyc, busy, done);
                miscompares++;
            end
            if (out_valid === 1'b1) begin
                eb = word / (NR*A);
                er = (word / A) % NR;
                ek = word % A;
                vectors++;
                if (out_data !== mem[eb][er][ek] || out_batch !== BW'(eb) || out_row !== MB'(er) ||
                    out_col !== CW'(ek) || out_last !== (word == TOTAL-1)) begin
                    $display("FAIL %s word %0d: data=%h b/r/c=%0d/%0d/%0d last=%b, required data=%h b/r/c=%0d/%0d/%0d last=%b",
                             name, word, out_data, out_batch, out_row, out_col, out_last,
                             mem[eb][er][ek], eb, er, ek, (word == TOTAL-1));
                    miscompares++;
                end
                if (word == reset_word) begin
                    srstn = 1'b0;
                    @(posedge clk); #1;
                    check_reset_outputs({name, "_after_reset"});
                    srstn = 1'b1;
                    out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    vectors++;
                    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                        $display("FAIL %s idle_after_reset: done=%b busy=%b valid=%b, required 0/0/0", name, done, busy, out_valid);
                        miscompares++;
                    end
                    return;
                end
            end
            out_ready = ($urandom_range(99) < ready_pct);
            start = (restart_word >= 0 && word >= restart_word && word < restart_word + 4);
            if (out_valid === 1'b1 && out_ready) word++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (word != TOTAL) begin
            $display("FAIL %s timeout: words=%0d, required %0d", name, word, TOTAL);
            miscompares++;
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL %s done_cycle: done=%b busy=%b valid=%b, required 1/0/0", name, done, busy, out_valid);
            miscompares++;
        end
        if (check_latency) begin
            vectors++;
            if (cyc != 1 + B*NR*(A+2)) begin
                $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, 1 + B*NR*(A+2));
                miscompares++;
            end
        end
        // A start in the done cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL %s after_done: done=%b busy=%b valid=%b, required 0/0/0", name, done, busy, out_valid);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mon_idx - mon_base != B*NR || mon_err != err0) begin
            $display("FAIL %s sram_reads: count=%0d errors=%0d, required %0d and 0", name, mon_idx - mon_base, mon_err - err0, B*NR);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        start = 1'b0;
        srstn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle_no_start");
    endtask

    task automatic test_full_rate();
        fill_pattern();
        run_transfer("full_rate", 100, -1, -1, 1'b1);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_transfer("backpressure", 50, -1, -1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        fill_pattern();
        run_transfer("restart_ignored", 100, 100, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        fill_random();
        run_transfer("reset_mid", 100, -1, 50, 1'b0);
        run_transfer("replay_after_reset", 70, -1, -1, 1'b0);
    endtask

    task automatic test_raw_bits();
        fill_random();
        for (int b = 0; b < B; b++)
            for (int r = 0; r < NR; r++) begin
                mem[b][r][0]   = 16'hFFFF;
                mem[b][r][A-1] = 16'h8000;
            end
        run_transfer("raw_bits", 60, -1, -1, 1'b0);
    endtask

    initial begin
        srstn = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        fill_pattern();
        test_reset();
        test_full_rate();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_raw_bits();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
